// File: rtl/knn_vote_if.sv
// knn_vote_if -- handshake bundle between the k-NN vote controller and its
// surroundings (sorter kick/result, sorted-type lookup, class result).
//   slave  : the controller side (knn_vote_ctrl)
//   master : the environment side (requester, sorter, class consumer)
// Signals: start, sort_done, valid_sort, type_idx, type_in,
//          class_out, class_valid, class_ack, busy, error.
interface knn_vote_if #(
    parameter int N      = 100,
    parameter int TYPE_W = 3
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic              start;
    logic              sort_done;
    logic              valid_sort;
    logic [IDX_W-1:0]  type_idx;
    logic [TYPE_W-1:0] type_in;
    logic [TYPE_W-1:0] class_out;
    logic              class_valid;
    logic              class_ack;
    logic              busy;
    logic              error;

    modport slave (
        input  start, valid_sort, type_in, class_ack,
        output sort_done, type_idx, class_out, class_valid, busy, error
    );

    modport master (
        output start, valid_sort, type_in, class_ack,
        input  sort_done, type_idx, class_out, class_valid, busy, error
    );
endinterface

// File: rtl/knn_vote_ctrl.sv
// knn_vote_ctrl -- majority vote over the K nearest neighbours.
// Kicks the sorter, waits (bounded) for its result, walks the first K sorted
// type labels one per cycle keeping per-class tallies, and presents the
// winning class until acknowledged. On a tie the class that reached the
// maximum first (in index order) wins.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - knn_vote_if.slave (start/sort_done/valid_sort/type_idx/type_in/
//          class_out/class_valid/class_ack/busy/error)
module knn_vote_ctrl #(
    parameter int N       = 100,
    parameter int TYPE_W  = 3,
    parameter int K       = 5,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    knn_vote_if.slave  bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(K + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int NCLS  = 1 << TYPE_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(K);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, KICK, WAIT_SORT, COUNT, DONE, ERR} state_t;

    state_t                      state;
    logic [NCLS-1:0][CNT_W-1:0]  votes;
    logic [CNT_W-1:0]            best_cnt;
    logic [TYPE_W-1:0]           best_cls;
    logic [TMO_W-1:0]            tmo_cnt;
    logic [CNT_W-1:0]            vote_inc;
    logic                        new_best;

    // Tally after this cycle's vote; saturating, though only K votes can
    // ever land, so the ceiling is a guard rather than a working limit.
    always_comb begin
        vote_inc = votes[bus.type_in];
        if (vote_inc != CNT_MAX)
            vote_inc = vote_inc + 1'b1;
        // strictly greater: an equal count never displaces the earlier leader
        new_best = (vote_inc > best_cnt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            bus.sort_done   <= 1'b0;
            bus.class_valid <= 1'b0;
            bus.busy        <= 1'b0;
            bus.error       <= 1'b0;
            bus.class_out   <= '0;
            bus.type_idx    <= '0;
            best_cnt        <= '0;
            best_cls        <= '0;
            votes           <= '0;
            tmo_cnt         <= '0;
        end else begin
            bus.sort_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state         <= KICK;
                        bus.sort_done <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                end
                KICK: begin
                    state   <= WAIT_SORT;
                    tmo_cnt <= '0;
                end
                WAIT_SORT: begin
                    // a result arriving on the timeout edge still counts
                    if (bus.valid_sort) begin
                        state        <= COUNT;
                        votes        <= '0;
                        bus.type_idx <= '0;
                        best_cnt     <= '0;
                        best_cls     <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state     <= ERR;
                        bus.error <= 1'b1;
                        bus.busy  <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                COUNT: begin
                    votes[bus.type_in] <= vote_inc;
                    if (new_best) begin
                        best_cnt <= vote_inc;
                        best_cls <= bus.type_in;
                    end
                    if (bus.type_idx == LAST_IDX) begin
                        // fold in the final vote directly; best_cls lands a cycle late
                        state           <= DONE;
                        bus.type_idx    <= '0;
                        bus.class_valid <= 1'b1;
                        bus.class_out   <= new_best ? bus.type_in : best_cls;
                    end else begin
                        bus.type_idx <= bus.type_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.class_ack) begin
                        state           <= IDLE;
                        bus.class_valid <= 1'b0;
                        bus.busy        <= 1'b0;
                    end
                end
                ERR: begin
                    if (bus.start) begin
                        state         <= KICK;
                        bus.error     <= 1'b0;
                        bus.sort_done <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_knn_vote_ctrl.sv
// tb_knn_vote_ctrl -- self-checking bench for knn_vote_ctrl.
// Two instances share clk/rst: d5 (K=5, TIMEOUT=16) and d1 (K=1). The sorter
// is modelled as a lookup array indexed by type_idx; expected classes come
// from a two-pass tally model (find the max count, then the first class in
// index order whose running count reaches it).
module tb_knn_vote_ctrl;
    localparam int N      = 100;
    localparam int TYPE_W = 3;
    localparam int K5     = 5;

    typedef logic [TYPE_W-1:0] vec_t [0:K5-1];

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    knn_vote_if #(.N(N), .TYPE_W(TYPE_W)) b5 ();
    knn_vote_if #(.N(N), .TYPE_W(TYPE_W)) b1 ();

    logic [TYPE_W-1:0] sorted5 [0:N-1];
    logic [TYPE_W-1:0] sorted1 [0:N-1];

    assign b5.type_in = sorted5[b5.type_idx];
    assign b1.type_in = sorted1[b1.type_idx];

    knn_vote_ctrl #(.N(N), .TYPE_W(TYPE_W), .K(K5), .TIMEOUT(16)) d5 (
        .clk(clk), .rst(rst), .bus(b5));
    knn_vote_ctrl #(.N(N), .TYPE_W(TYPE_W), .K(1), .TIMEOUT(16)) d1 (
        .clk(clk), .rst(rst), .bus(b1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TYPE_W-1:0] ref_vote(input vec_t v);
        int tally [8];
        int run [8];
        int mx;
        for (int c = 0; c < 8; c++) begin tally[c] = 0; run[c] = 0; end
        for (int i = 0; i < K5; i++) tally[v[i]]++;
        mx = 0;
        for (int c = 0; c < 8; c++) if (tally[c] > mx) mx = tally[c];
        for (int i = 0; i < K5; i++) begin
            run[v[i]]++;
            if (run[v[i]] == mx) return v[i];
        end
        return '0;
    endfunction

    // Runs one classification on d5 and leaves it waiting in DONE.
    task automatic do_vote(input vec_t v, input int dly, input string nm);
        int n;
        logic [TYPE_W-1:0] exp;
        exp = ref_vote(v);
        for (int i = 0; i < K5; i++) sorted5[i] = v[i];
        b5.start = 1'b1;
        tick();
        b5.start = 1'b0;
        checks++;
        if (b5.sort_done !== 1'b1 || b5.busy !== 1'b1 || b5.error !== 1'b0) begin
            failures++;
            $display("FAIL %s kick: sort_done=%b busy=%b error=%b, want 1 1 0",
                     nm, b5.sort_done, b5.busy, b5.error);
        end
        tick();
        checks++;
        if (b5.sort_done !== 1'b0) begin
            failures++;
            $display("FAIL %s kick_len: sort_done=%b, want 0", nm, b5.sort_done);
        end
        repeat (dly - 1) tick();
        b5.valid_sort = 1'b1;
        tick();
        b5.valid_sort = 1'b0;
        n = 0;
        while (b5.class_valid !== 1'b1 && n < 4 * K5) begin
            tick();
            n++;
        end
        checks++;
        if (n != K5) begin
            failures++;
            $display("FAIL %s latency: got %0d edges, want %0d", nm, n, K5);
        end
        checks++;
        if (b5.class_out !== exp) begin
            failures++;
            $display("FAIL %s class: got %0d, want %0d", nm, b5.class_out, exp);
        end
    endtask

    task automatic do_ack(input string nm);
        b5.class_ack = 1'b1;
        tick();
        b5.class_ack = 1'b0;
        checks++;
        if (b5.class_valid !== 1'b0 || b5.busy !== 1'b0 || b5.type_idx !== '0) begin
            failures++;
            $display("FAIL %s ack: class_valid=%b busy=%b type_idx=%0d, want 0 0 0",
                     nm, b5.class_valid, b5.busy, b5.type_idx);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (b5.sort_done !== 1'b0 || b5.class_valid !== 1'b0 || b5.busy !== 1'b0 ||
            b5.error !== 1'b0 || b5.class_out !== '0 || b5.type_idx !== '0 ||
            b1.class_valid !== 1'b0 || b1.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset: sd=%b cv=%b busy=%b err=%b cls=%0d idx=%0d, want all 0",
                     b5.sort_done, b5.class_valid, b5.busy, b5.error, b5.class_out, b5.type_idx);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_directed();
        do_vote('{3'd1, 3'd2, 3'd1, 3'd3, 3'd2}, 3, "basic");
        do_ack("basic");
        do_vote('{3'd2, 3'd1, 3'd1, 3'd2, 3'd3}, 2, "tie_a");
        do_ack("tie_a");
        do_vote('{3'd3, 3'd3, 3'd5, 3'd5, 3'd1}, 1, "tie_b");
        do_ack("tie_b");
        do_vote('{3'd4, 3'd4, 3'd4, 3'd4, 3'd4}, 4, "unanimous");
        do_ack("unanimous");
    endtask

    task automatic test_random();
        vec_t v;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < K5; i++) v[i] = TYPE_W'($urandom_range(0, 7));
            do_vote(v, int'($urandom_range(1, 6)), "random");
            repeat ($urandom_range(0, 2)) tick();
            do_ack("random");
        end
    endtask

    task automatic test_k1();
        int n;
        sorted1[0] = 3'd6;
        sorted1[1] = 3'd2;
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        tick();
        tick();
        b1.valid_sort = 1'b1;
        tick();
        b1.valid_sort = 1'b0;
        n = 0;
        while (b1.class_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (n != 1 || b1.class_out !== 3'd6) begin
            failures++;
            $display("FAIL k1: latency=%0d class=%0d, want 1 6", n, b1.class_out);
        end
        b1.class_ack = 1'b1;
        tick();
        b1.class_ack = 1'b0;
        checks++;
        if (b1.class_valid !== 1'b0 || b1.busy !== 1'b0) begin
            failures++;
            $display("FAIL k1_ack: class_valid=%b busy=%b, want 0 0", b1.class_valid, b1.busy);
        end
    endtask

    task automatic test_backpressure();
        vec_t v;
        logic [TYPE_W-1:0] exp;
        int bad;
        v = '{3'd7, 3'd0, 3'd0, 3'd7, 3'd6};
        exp = ref_vote(v);
        do_vote(v, 2, "bp");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            b5.start = (i == 3 || i == 4);
            tick();
            if (b5.class_valid !== 1'b1 || b5.class_out !== exp ||
                b5.sort_done !== 1'b0 || b5.busy !== 1'b1) bad++;
        end
        b5.start = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold: %0d bad cycles, want 0 (class=%0d want %0d)",
                     bad, b5.class_out, exp);
        end
        do_ack("bp");
        tick();
        checks++;
        if (b5.sort_done !== 1'b0 || b5.busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle: sort_done=%b busy=%b, want 0 0", b5.sort_done, b5.busy);
        end
    endtask

    task automatic test_timeout();
        int bad;
        b5.start = 1'b1;
        tick();
        b5.start = 1'b0;
        tick();                 // WAIT_SORT entry edge
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            b5.class_ack = (i == 5);
            tick();
            if (i < 16 && (b5.error !== 1'b0 || b5.busy !== 1'b1)) bad++;
        end
        b5.class_ack = 1'b0;
        checks++;
        if (bad != 0 || b5.error !== 1'b1 || b5.busy !== 1'b0 || b5.class_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout: early=%0d error=%b busy=%b cv=%b, want 0 1 0 0",
                     bad, b5.error, b5.busy, b5.class_valid);
        end
        b5.valid_sort = 1'b1;
        repeat (3) tick();
        b5.valid_sort = 1'b0;
        checks++;
        if (b5.error !== 1'b1 || b5.busy !== 1'b0 || b5.type_idx !== '0) begin
            failures++;
            $display("FAIL err_sticky: error=%b busy=%b idx=%0d, want 1 0 0",
                     b5.error, b5.busy, b5.type_idx);
        end
        do_vote('{3'd5, 3'd2, 3'd2, 3'd5, 3'd0}, 3, "after_err");
        do_ack("after_err");
    endtask

    task automatic test_reset_mid_count();
        for (int i = 0; i < K5; i++) sorted5[i] = 3'd7;
        b5.start = 1'b1;
        tick();
        b5.start = 1'b0;
        tick();
        b5.valid_sort = 1'b1;
        tick();
        b5.valid_sort = 1'b0;
        tick();
        tick();
        checks++;
        if (b5.type_idx !== 7'd2) begin
            failures++;
            $display("FAIL mid_idx: type_idx=%0d, want 2", b5.type_idx);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (b5.sort_done !== 1'b0 || b5.class_valid !== 1'b0 || b5.busy !== 1'b0 ||
            b5.error !== 1'b0 || b5.class_out !== '0 || b5.type_idx !== '0) begin
            failures++;
            $display("FAIL mid_reset: sd=%b cv=%b busy=%b err=%b cls=%0d idx=%0d, want all 0",
                     b5.sort_done, b5.class_valid, b5.busy, b5.error, b5.class_out, b5.type_idx);
        end
        #3;
        rst = 1'b1;
        // stale 7-votes would make 7 win here
        do_vote('{3'd1, 3'd7, 3'd1, 3'd7, 3'd2}, 2, "post_reset");
        do_ack("post_reset");
    endtask

    initial begin
        b5.start = 1'b0; b5.valid_sort = 1'b0; b5.class_ack = 1'b0;
        b1.start = 1'b0; b1.valid_sort = 1'b0; b1.class_ack = 1'b0;
        for (int i = 0; i < N; i++) begin sorted5[i] = '0; sorted1[i] = '0; end
        test_reset();
        test_directed();
        test_k1();
        test_backpressure();
        test_timeout();
        test_reset_mid_count();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
